controlador_de_senha: RTL and testbench



---
 rtl/controlador_de_senha.sv | 184 ++++++++++++++++++
 tb/tb_controlador_de_senha.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_de_senha.sv
// Password/lock controller: verifies keypad frames, times the unlock window and the lockout,
// and reprograms the user password under the master password. Optional alarm build: CONTROLADOR_ALARME_EN.
module controlador_de_senha #(
    parameter logic [79:0] SENHA_PADRAO     = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4},
    parameter logic [79:0] SENHA_MESTRE     = {{14{4'hF}}, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4},
    parameter int          TEMPO_DESTRAVADO = 5000,
    parameter int          TEMPO_BLOQUEIO   = 50000,
    parameter int          MAX_TENTATIVAS   = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [79:0]                           digitos_value,
    input  logic                                  digitos_valid,
    output logic                                  teclado_enable,
    output logic                                  trava,
    output logic                                  senha_ok,
    output logic                                  senha_erro,
    output logic                                  modo_programacao,
    output logic                                  bloqueado,
    output logic                                  alarme,
    output logic [$clog2(MAX_TENTATIVAS+1)-1:0]   tentativas
);
    // state      | meaning
    // ESPERA     | idle, keypad enabled, waiting for a password
    // DESTRAVADO | door unlocked for TEMPO_DESTRAVADO cycles
    // PROGRAMAR  | master accepted, waiting for the new password
    // CONFIRMAR  | waiting for the new password a second time
    // BLOQUEIO   | lockout after MAX_TENTATIVAS consecutive failures
    typedef enum logic [2:0] {ESPERA, DESTRAVADO, PROGRAMAR, CONFIRMAR, BLOQUEIO} estado_t;

    localparam int          TW       = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [79:0] TODO_F   = {20{4'hF}};
    localparam logic [79:0] TODO_B   = {20{4'hB}};
    localparam logic [79:0] TODO_E   = {20{4'hE}};
`ifdef CONTROLADOR_ALARME_EN
    localparam logic        ALARME_EN = 1'b1;
`else
    localparam logic        ALARME_EN = 1'b0;
`endif

    estado_t     estado;
    logic [79:0] senha_usuario;
    logic [79:0] candidato;
    logic [31:0] contador;

    logic        eh_cancela, eh_digitos;
    logic [4:0]  comprimento;
    logic        malformado, fim;
    logic [3:0]  nib;

    assign eh_cancela = digitos_valid && (digitos_value == TODO_B || digitos_value == TODO_E);
    assign eh_digitos = digitos_valid && digitos_value != TODO_F &&
                        digitos_value != TODO_B && digitos_value != TODO_E;

    // Length runs from the newest key up to the first F; any key after that gap is malformed.
    always_comb begin
        comprimento = 5'd0;
        malformado  = 1'b0;
        fim         = 1'b0;
        nib         = 4'hF;
        for (int i = 0; i < 20; i++) begin
            nib = digitos_value[4*i +: 4];
            if (!fim) begin
                if (nib == 4'hF) begin
                    fim = 1'b1;
                end else begin
                    comprimento = comprimento + 5'd1;
                    if (nib >= 4'hA && nib <= 4'hE) malformado = 1'b1;
                end
            end else if (nib != 4'hF) begin
                malformado = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado           <= ESPERA;
            senha_usuario    <= SENHA_PADRAO;
            candidato        <= TODO_F;
            contador         <= '0;
            teclado_enable   <= 1'b1;
            trava            <= 1'b1;
            senha_ok         <= 1'b0;
            senha_erro       <= 1'b0;
            modo_programacao <= 1'b0;
            bloqueado        <= 1'b0;
            alarme           <= 1'b0;
            tentativas       <= '0;
        end else begin
            senha_ok   <= 1'b0;
            senha_erro <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (eh_digitos) begin
                        if (digitos_value == senha_usuario) begin
                            estado         <= DESTRAVADO;
                            contador       <= '0;
                            trava          <= 1'b0;
                            teclado_enable <= 1'b0;
                            senha_ok       <= 1'b1;
                            tentativas     <= '0;
                        end else if (digitos_value == SENHA_MESTRE) begin
                            estado           <= PROGRAMAR;
                            modo_programacao <= 1'b1;
                            tentativas       <= '0;
                        end else begin
                            senha_erro <= 1'b1;
                            if (tentativas >= TW'(MAX_TENTATIVAS - 1)) begin
                                estado         <= BLOQUEIO;
                                contador       <= '0;
                                tentativas     <= TW'(MAX_TENTATIVAS);
                                bloqueado      <= 1'b1;
                                teclado_enable <= ALARME_EN;
                                alarme         <= ALARME_EN;
                            end else begin
                                tentativas <= tentativas + 1'b1;
                            end
                        end
                    end
                end
                DESTRAVADO: begin
                    if (contador == 32'(TEMPO_DESTRAVADO - 1)) begin
                        estado         <= ESPERA;
                        trava          <= 1'b1;
                        teclado_enable <= 1'b1;
                    end else begin
                        contador <= contador + 32'd1;
                    end
                end
                PROGRAMAR: begin
                    if (eh_cancela) begin
                        estado           <= ESPERA;
                        modo_programacao <= 1'b0;
                    end else if (eh_digitos) begin
                        if (!malformado && comprimento >= 5'd4) begin
                            estado    <= CONFIRMAR;
                            candidato <= digitos_value;
                        end else begin
                            senha_erro <= 1'b1;
                        end
                    end
                end
                CONFIRMAR: begin
                    if (eh_cancela) begin
                        estado           <= ESPERA;
                        modo_programacao <= 1'b0;
                    end else if (eh_digitos) begin
                        estado           <= ESPERA;
                        modo_programacao <= 1'b0;
                        if (digitos_value == candidato) begin
                            senha_usuario <= candidato;
                            senha_ok      <= 1'b1;
                        end else begin
                            senha_erro <= 1'b1;
                        end
                    end
                end
                BLOQUEIO: begin
`ifdef CONTROLADOR_ALARME_EN
                    // Only the master clears the alarm; nothing expires by time here.
                    if (eh_digitos && digitos_value == SENHA_MESTRE) begin
                        estado         <= ESPERA;
                        alarme         <= 1'b0;
                        bloqueado      <= 1'b0;
                        tentativas     <= '0;
                        teclado_enable <= 1'b1;
                    end
`else
                    if (contador == 32'(TEMPO_BLOQUEIO - 1)) begin
                        estado         <= ESPERA;
                        bloqueado      <= 1'b0;
                        tentativas     <= '0;
                        teclado_enable <= 1'b1;
                    end else begin
                        contador <= contador + 32'd1;
                    end
`endif
                end
                default: estado <= ESPERA;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_de_senha.sv
// Scoreboard bench for controlador_de_senha: stimulus queues expected ok/erro pulses,
// a negedge monitor pops them as the DUT pulses; level outputs are checked inline.
`timescale 1ns/1ps
module tb_controlador_de_senha;
    localparam logic [79:0] F_ALL    = {20{4'hF}};
    localparam logic [79:0] B_ALL    = {20{4'hB}};
    localparam logic [79:0] S_1234   = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};
    localparam logic [79:0] S_5555   = {{16{4'hF}}, 4'h5, 4'h5, 4'h5, 4'h5};
    localparam logic [79:0] S_MESTRE = {{14{4'hF}}, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
    localparam logic [79:0] S_24680  = {{15{4'hF}}, 4'h2, 4'h4, 4'h6, 4'h8, 4'h0};
    localparam logic [79:0] S_13579  = {{15{4'hF}}, 4'h1, 4'h3, 4'h5, 4'h7, 4'h9};
    localparam logic [79:0] S_12     = {{18{4'hF}}, 4'h1, 4'h2};
    localparam logic [79:0] S_12A4   = {{16{4'hF}}, 4'h1, 4'h2, 4'hA, 4'h4};
    localparam logic [79:0] S_BURACO = {{15{4'hF}}, 4'h1, 4'hF, 4'h2, 4'h3, 4'h4};
    localparam logic [1:0]  P_OK   = 2'b01;
    localparam logic [1:0]  P_ERRO = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic        teclado_enable, trava, senha_ok, senha_erro;
    logic        modo_programacao, bloqueado, alarme;
    logic [1:0]  tentativas;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  fila[$];
    logic [1:0]  esperado_pulso;

    controlador_de_senha dut (
        .clk(clk), .rst(rst),
        .digitos_value(digitos_value), .digitos_valid(digitos_valid),
        .teclado_enable(teclado_enable), .trava(trava),
        .senha_ok(senha_ok), .senha_erro(senha_erro),
        .modo_programacao(modo_programacao), .bloqueado(bloqueado),
        .alarme(alarme), .tentativas(tentativas)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && (senha_ok || senha_erro)) begin
            if (fila.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulso_inesperado: got ok=%0b erro=%0b expected none", senha_ok, senha_erro);
            end else begin
                esperado_pulso = fila.pop_front();
                check("pulso", {30'd0, senha_erro, senha_ok}, {30'd0, esperado_pulso});
            end
        end
    end

    // Frame is sampled on the second edge; returns 1ns after it with the line back to LIMPO.
    task automatic envia(input logic [79:0] v);
        @(posedge clk); #1;
        digitos_value = v;
        digitos_valid = 1'b1;
        @(posedge clk); #1;
        digitos_value = F_ALL;
        digitos_valid = 1'b1;
    endtask

    task automatic espera_destravado(input string nome, input int esperado);
        int n = 0;
        logic teclado_ok = 1'b1;
        while (trava == 1'b0 && n < 6000) begin
            if (teclado_enable !== 1'b0) teclado_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({nome, "_duracao"}, n, esperado);
        check({nome, "_teclado_off"}, {31'd0, teclado_ok}, 1);
        check({nome, "_teclado_volta"}, {31'd0, teclado_enable}, 1);
    endtask

    task automatic verifica_reset(input string nome);
        check({nome, "_saidas"},
              {24'd0, teclado_enable, trava, senha_ok, senha_erro, modo_programacao, bloqueado, alarme, 1'b0},
              {24'd0, 8'b1100_0000});
        check({nome, "_tentativas"}, {30'd0, tentativas}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        digitos_value = F_ALL;
        digitos_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        verifica_reset("reset");
        rst = 1'b1;

        // unlock with default password, a frame inside the window is ignored
        fila.push_back(P_OK);
        envia(S_1234);
        check("t1_trava", {31'd0, trava}, 0);
        check("t1_teclado", {31'd0, teclado_enable}, 0);
        envia(S_5555);
        espera_destravado("t1", 4998);
        check("t1_tentativas", {30'd0, tentativas}, 0);

        // three failures -> lockout
        fila.push_back(P_ERRO);
        envia(S_5555);
        check("t2_tent1", {30'd0, tentativas}, 1);
        fila.push_back(P_ERRO);
        envia(S_5555);
        check("t2_tent2", {30'd0, tentativas}, 2);
        check("t2_nao_bloq", {31'd0, bloqueado}, 0);
        fila.push_back(P_ERRO);
        envia(S_5555);
        check("t2_bloq", {31'd0, bloqueado}, 1);
        check("t2_tent3", {30'd0, tentativas}, 3);
        envia(S_1234);
        check("t2_ignora_trava", {31'd0, trava}, 1);
`ifdef CONTROLADOR_ALARME_EN
        check("t2_alarme", {31'd0, alarme}, 1);
        check("t2_teclado", {31'd0, teclado_enable}, 1);
        repeat (50010) @(posedge clk);
        #1;
        check("t2_alarme_persiste", {31'd0, alarme}, 1);
        check("t2_bloq_persiste", {31'd0, bloqueado}, 1);
        envia(S_MESTRE);
        check("t2_alarme_limpo", {31'd0, alarme}, 0);
        check("t2_bloq_limpo", {31'd0, bloqueado}, 0);
        check("t2_modo", {31'd0, modo_programacao}, 0);
`else
        check("t2_alarme", {31'd0, alarme}, 0);
        check("t2_teclado", {31'd0, teclado_enable}, 0);
        begin
            int n = 0;
            while (bloqueado == 1'b1 && n < 51000) begin
                @(posedge clk); #1;
                n++;
            end
            check("t2_duracao", n, 49998);
        end
`endif
        check("t2_tent_zero", {30'd0, tentativas}, 0);
        check("t2_teclado_volta", {31'd0, teclado_enable}, 1);

        // master, short and gapped entries rejected, cancel keeps 1234
        envia(S_MESTRE);
        check("t4_modo", {31'd0, modo_programacao}, 1);
        fila.push_back(P_ERRO);
        envia(S_12);
        check("t4_modo_apos_curta", {31'd0, modo_programacao}, 1);
        fila.push_back(P_ERRO);
        envia(S_BURACO);
        check("t4_modo_apos_buraco", {31'd0, modo_programacao}, 1);
        envia(B_ALL);
        check("t4_cancela", {31'd0, modo_programacao}, 0);
        fila.push_back(P_OK);
        envia(S_1234);
        check("t4_senha_mantida", {31'd0, trava}, 0);
        espera_destravado("t4", 5000);

        // LIMPO frames ignored, malformed frame rejected
        envia(F_ALL);
        check("t5_limpo", {30'd0, tentativas}, 0);
        fila.push_back(P_ERRO);
        envia(S_12A4);
        check("t5_12a4", {30'd0, tentativas}, 1);

        // reprogram to 24680
        envia(S_MESTRE);
        check("t3_tent_limpa", {30'd0, tentativas}, 0);
        envia(S_24680);
        check("t3_modo_confirmar", {31'd0, modo_programacao}, 1);
        fila.push_back(P_OK);
        envia(S_24680);
        check("t3_modo_fim", {31'd0, modo_programacao}, 0);
        fila.push_back(P_OK);
        envia(S_24680);
        check("t3_nova_destrava", {31'd0, trava}, 0);
        espera_destravado("t3", 5000);
        fila.push_back(P_ERRO);
        envia(S_1234);
        check("t3_antiga_rejeitada", {30'd0, tentativas}, 1);

        // reset in CONFIRMAR reverts the password
        envia(S_MESTRE);
        envia(S_13579);
        check("t6_confirmar", {31'd0, modo_programacao}, 1);
        #2;
        rst = 1'b0;
        #1;
        verifica_reset("t6_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        fila.push_back(P_OK);
        envia(S_1234);
        check("t6_senha_padrao", {31'd0, trava}, 0);
        espera_destravado("t6", 5000);

        repeat (5) @(posedge clk);
        #1;
        check("fila_vazia", fila.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
